dcache_direct: RTL

- Direct-mapped, write-through, no-write-allocate data cache between the pipeline MEM stage and the multi-cycle data memory.
- Read hits return data in the same cycle.
- Read misses stall the pipeline while the cache runs the memory's read/stall handshake and fills the line.
- Writes always go straight through to memory.
- One-word lines; one outstanding request at a time.

---
 rtl/dcache_direct.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dcache_direct.sv
// dcache_direct - direct-mapped, write-through, no-write-allocate data cache
// that sits between the pipeline MEM stage and a multi-cycle data memory.
// Lines are one word long, and only one memory request is outstanding at a time.
//
// Ports:
//   clk, reset          system clock; asynchronous active-high reset
//   read, write         pipeline load / store requests (sampled only in IDLE)
//   address             byte address; bits [1:0] ignored
//   write_data          store data
//   read_data           load data, valid when read=1 and stall=0
//   stall               freezes the pipeline while a miss is in progress
//   mem_read/mem_write  requests to data memory
//   mem_address         address to data memory
//   mem_write_data      store data to data memory
//   mem_read_data       fill data from data memory
//   mem_stall           data memory busy
//   hit_count, miss_count, write_count
//                       saturating event counters, present only when the
//                       DCACHE_STATS_EN macro is defined
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | serve hits and write-throughs; launch a read miss
// MISS_WAIT | hold mem_read until memory has stalled and then released
// FILL      | one cycle presenting the filled word to the pipeline

module dcache_direct #(
   parameter int INDEX_BITS = 4,
   localparam int TAG_BITS  = 30 - INDEX_BITS,
   localparam int LINES     = 1 << INDEX_BITS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        stall,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   input  logic        mem_stall
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
   output logic [31:0] write_count
`endif
);

   typedef enum logic [1:0] {IDLE, MISS_WAIT, FILL} state_t;

   state_t                state_q;
   logic [LINES-1:0]      valid_q;
   logic [TAG_BITS-1:0]   tag_q  [LINES];
   logic [31:0]           data_q [LINES];
   logic [31:0]           miss_addr_q;
   logic [31:0]           fill_data_q;
   logic [31:0]           hold_q;
   logic                  seen_stall_q;

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   addr_tag;
   logic [INDEX_BITS-1:0] miss_idx;
   logic [TAG_BITS-1:0]   miss_tag;
   logic                  hit;
   logic                  in_idle;
   logic                  do_write;
   logic                  do_read;
   logic                  read_hit;
   logic                  read_miss;
   logic                  fill_now;
   logic                  unused_addr_bits;

   assign idx              = address[INDEX_BITS+1:2];
   assign addr_tag         = address[31:INDEX_BITS+2];
   assign miss_idx         = miss_addr_q[INDEX_BITS+1:2];
   assign miss_tag         = miss_addr_q[31:INDEX_BITS+2];
   assign unused_addr_bits = ^address[1:0];

   assign hit = valid_q[idx] && (tag_q[idx] == addr_tag);

   // Gating with reset keeps every request output low while reset is held,
   // even if the pipeline is still presenting a request.
   assign in_idle   = (state_q == IDLE) && !reset;
   assign do_write  = in_idle && write;
   assign do_read   = in_idle && read && !write;
   assign read_hit  = do_read && hit;
   assign read_miss = do_read && !hit;

   // Memory must have shown mem_stall at least once before a low mem_stall
   // means the data is there; the first MISS_WAIT cycle precedes any response.
   assign fill_now = (state_q == MISS_WAIT) && !mem_stall && seen_stall_q;

   always_comb begin
      stall          = read_miss || (state_q == MISS_WAIT);
      mem_read       = stall;
      mem_write      = do_write;
      mem_write_data = do_write ? write_data : '0;
      if (do_write || read_miss)
         mem_address = address;
      else if (state_q == MISS_WAIT)
         mem_address = miss_addr_q;
      else
         mem_address = '0;
      if (read_hit)
         read_data = data_q[idx];
      else if (state_q == FILL)
         read_data = fill_data_q;
      else
         read_data = hold_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         seen_stall_q <= 1'b0;
         miss_addr_q  <= '0;
         fill_data_q  <= '0;
         hold_q       <= '0;
      end else begin
         if (read_hit || state_q == FILL)
            hold_q <= read_data;
         case (state_q)
            IDLE: begin
               if (read_miss) begin
                  miss_addr_q  <= address;
                  seen_stall_q <= 1'b0;
                  state_q      <= MISS_WAIT;
               end
            end
            MISS_WAIT: begin
               if (mem_stall) begin
                  seen_stall_q <= 1'b1;
               end else if (seen_stall_q) begin
                  fill_data_q       <= mem_read_data;
                  valid_q[miss_idx] <= 1'b1;
                  state_q           <= FILL;
               end
            end
            FILL:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tag and data arrays need no reset; valid_q alone qualifies them.
   always_ff @(posedge clk) begin
      if (do_write && hit)
         data_q[idx] <= write_data;
      if (fill_now) begin
         data_q[miss_idx] <= mem_read_data;
         tag_q[miss_idx]  <= miss_tag;
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count   <= '0;
         miss_count  <= '0;
         write_count <= '0;
      end else begin
         if (read_hit && hit_count != 32'hFFFF_FFFF)
            hit_count <= hit_count + 32'd1;
         if (read_miss && miss_count != 32'hFFFF_FFFF)
            miss_count <= miss_count + 32'd1;
         if (do_write && write_count != 32'hFFFF_FFFF)
            write_count <= write_count + 32'd1;
      end
   end
`endif

endmodule
